// File: rtl/instr_loader.sv
// Instruction RAM loader: packs decoded instruction fields into 9-bit words and writes them
// to sequential addresses from 0, reporting program length, completion and overflow.
module instr_loader #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_format,
    input  logic [3:0]        in_opcode,
    input  logic              in_sign,
    input  logic [2:0]        in_operand,
    input  logic [7:0]        in_immediate,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W-1:0] prog_len
);

    localparam logic [ADDR_W-1:0] DepthW = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [8:0]        wr_data_q, wr_data_d;
    logic [8:0]        packed_word;
    logic [ADDR_W-1:0] count_inc;
    logic              accept;

    // Ready is a pure function of registered state so the source never sees a comb loop.
    assign in_ready    = (state_q == StLoad) && (count_q < DepthW);
    assign accept      = in_valid && in_ready;
    assign packed_word = in_format ? {1'b1, in_opcode, in_sign, in_operand}
                                   : {1'b0, in_immediate};
    assign count_inc   = count_q + ADDR_W'(1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (start) begin
            // Start wins over any word presented in the same cycle.
            state_d    = StLoad;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (accept) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = count_q;
                        wr_data_d = packed_word;
                        count_d   = count_inc;
                        if (in_last) begin
                            state_d = StDone;
                        end else if (count_inc == DepthW) begin
                            state_d    = StDone;
                            overflow_d = 1'b1;
                        end
                    end
                end
                StIdle, StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == StLoad);
    assign done     = (state_q == StDone);
    assign overflow = overflow_q;
    assign prog_len = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a default-depth instance (a) and a DEPTH=4 instance (b)
// share the source fields; each has its own start and expected-write queue.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_format = 1'b0, in_sign = 1'b0, in_last = 1'b0;
    logic [3:0]  in_opcode = '0;
    logic [2:0]  in_operand = '0;
    logic [7:0]  in_immediate = '0;

    logic        ready_a, wr_en_a, busy_a, done_a, ovf_a;
    logic [15:0] wr_addr_a, len_a;
    logic [8:0]  wr_data_a;
    logic        ready_b, wr_en_b, busy_b, done_b, ovf_b;
    logic [15:0] wr_addr_b, len_b;
    logic [8:0]  wr_data_b;

    int unsigned n_tests = 0, n_fail = 0;
    int unsigned writes_a = 0, writes_b = 0;
    int unsigned cnt_a = 0, cnt_b = 0;
    logic [24:0] qa[$], qb[$];

    always #5 clk = ~clk;

    instr_loader u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_ready(ready_a),
        .in_format(in_format), .in_opcode(in_opcode), .in_sign(in_sign),
        .in_operand(in_operand), .in_immediate(in_immediate), .in_last(in_last),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a),
        .done(done_a), .overflow(ovf_a), .prog_len(len_a)
    );

    instr_loader #(.ADDR_W(16), .DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(ready_b),
        .in_format(in_format), .in_opcode(in_opcode), .in_sign(in_sign),
        .in_operand(in_operand), .in_immediate(in_immediate), .in_last(in_last),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b),
        .done(done_b), .overflow(ovf_b), .prog_len(len_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Writes are stable between edges; pop the oldest expected word on each strobe.
    always @(negedge clk) begin
        logic [24:0] e;
        if (wr_en_a) begin
            writes_a++;
            check_eq("a_pending", qa.size(), (qa.size() == 0) ? 1 : qa.size());
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check_eq("a_wr_addr", {16'h0, wr_addr_a}, {16'h0, e[24:9]});
                check_eq("a_wr_data", {23'h0, wr_data_a}, {23'h0, e[8:0]});
            end else begin
                check_eq("a_spurious_write", 1, 0);
            end
        end
        if (wr_en_b) begin
            writes_b++;
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check_eq("b_wr_addr", {16'h0, wr_addr_b}, {16'h0, e[24:9]});
                check_eq("b_wr_data", {23'h0, wr_data_b}, {23'h0, e[8:0]});
            end else begin
                check_eq("b_spurious_write", 1, 0);
            end
        end
    end

    // Called just after a falling edge; returns after the next falling edge.
    task automatic drive_word(input bit use_b, input bit fmt, input logic [3:0] opc,
                              input bit sgn, input logic [2:0] opr, input logic [7:0] imm,
                              input bit last, output bit acc);
        logic [8:0] w;
        in_format = fmt; in_opcode = opc; in_sign = sgn; in_operand = opr;
        in_immediate = imm; in_last = last; in_valid = 1'b1;
        w = fmt ? {1'b1, opc, sgn, opr} : {1'b0, imm};
        acc = use_b ? ready_b : ready_a;
        if (acc) begin
            if (use_b) begin qb.push_back({cnt_b[15:0], w}); cnt_b++; end
            else       begin qa.push_back({cnt_a[15:0], w}); cnt_a++; end
        end
        @(negedge clk);
    endtask

    task automatic rand_word(input bit use_b, input bit last, output bit acc);
        drive_word(use_b, 1'($urandom), 4'($urandom), 1'($urandom), 3'($urandom),
                   8'($urandom), last, acc);
    endtask

    task automatic pulse_start(input bit use_b);
        if (use_b) begin start_b = 1'b1; cnt_b = 0; end
        else       begin start_a = 1'b1; cnt_a = 0; end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int unsigned w0;

        #1;
        check_eq("rst_async_outs", {ready_a, wr_en_a, busy_a, done_a, ovf_a}, 0);
        #21 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready_flags", {ready_a, wr_en_a, busy_a, done_a, ovf_a, ready_b}, 0);
        check_eq("rst_addr_data", {wr_addr_a, 7'h0, wr_data_a}, 0);
        check_eq("rst_prog_len", {16'h0, len_a}, 0);

        // Two-word program: one op-format word then an immediate with last.
        pulse_start(0);
        check_eq("t1_busy", {busy_a, done_a, ready_a}, 3'b101);
        drive_word(0, 1, 4'b0001, 0, 3'b000, 8'hA5, 0, acc);
        check_eq("t1_acc0", acc, 1);
        check_eq("t1_data0", {23'h0, wr_data_a}, 32'h110);
        check_eq("t1_len0", {16'h0, len_a}, 1);
        drive_word(0, 0, 4'hF, 1, 3'h7, 8'h1F, 1, acc);
        check_eq("t1_data1", {23'h0, wr_data_a}, 32'h01F);
        check_eq("t1_addr1", {16'h0, wr_addr_a}, 1);
        check_eq("t1_done", {done_a, busy_a, ready_a}, 3'b100);
        check_eq("t1_len1", {16'h0, len_a}, 2);
        // Valid while DONE must not write.
        rand_word(0, 0, acc);
        rand_word(0, 0, acc);
        check_eq("t1_done_ignored_acc", acc, 0);
        idle_cycle();

        // 35-word back-to-back stream.
        pulse_start(0);
        w0 = writes_a;
        for (int i = 1; i <= 35; i++) begin
            rand_word(0, i == 35, acc);
            check_eq("t3_acc", acc, 1);
        end
        idle_cycle();
        check_eq("t3_writes", writes_a - w0, 35);
        check_eq("t3_done_ovf", {done_a, ovf_a, busy_a}, 3'b100);
        check_eq("t3_len", {16'h0, len_a}, 35);

        // DEPTH=4 overflow on instance b.
        pulse_start(1);
        for (int i = 1; i <= 6; i++) begin
            rand_word(1, 0, acc);
            check_eq($sformatf("t4_acc%0d", i), acc, (i <= 4) ? 1 : 0);
        end
        idle_cycle();
        check_eq("t4_writes", writes_b, 4);
        check_eq("t4_flags", {done_b, ovf_b, ready_b, busy_b}, 4'b1100);
        check_eq("t4_len", {16'h0, len_b}, 4);
        pulse_start(1);
        check_eq("t4_ovf_cleared", {ovf_b, busy_b, done_b}, 3'b010);
        check_eq("t4_len_cleared", {16'h0, len_b}, 0);
        for (int i = 1; i <= 4; i++) rand_word(1, i == 4, acc);
        idle_cycle();
        check_eq("t4_full_last", {done_b, ovf_b}, 2'b10);

        // Stalling source, then restart mid-load with a word presented alongside start.
        pulse_start(0);
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            idle_cycle();
            rand_word(0, 0, acc);
            check_eq("t5_acc", acc, 1);
        end
        check_eq("t5_len3", {16'h0, len_a}, 3);
        in_valid = 1'b1;
        pulse_start(0);
        check_eq("t5_restart_len", {16'h0, len_a}, 0);
        check_eq("t5_restart_busy", {busy_a, done_a}, 2'b10);
        rand_word(0, 0, acc);
        check_eq("t5_new_addr", {16'h0, wr_addr_a}, 0);
        check_eq("t5_new_len", {16'h0, len_a}, 1);
        rand_word(0, 1, acc);
        idle_cycle();
        check_eq("t5_done", {done_a, ovf_a}, 2'b10);

        // Asynchronous reset while a write strobe is on the outputs.
        pulse_start(0);
        rand_word(0, 0, acc);
        rand_word(0, 0, acc);
        check_eq("t6_pre_wr_en", wr_en_a, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_flags", {wr_en_a, busy_a, done_a, ovf_a, ready_a}, 0);
        check_eq("t6_rst_vals", {wr_addr_a, len_a}, 0);
        check_eq("t6_rst_data", {23'h0, wr_data_a}, 0);
        qa.delete();
        cnt_a = 0;
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        pulse_start(0);
        rand_word(0, 1, acc);
        check_eq("t6_reload_addr", {16'h0, wr_addr_a}, 0);
        idle_cycle();
        check_eq("t6_reload_done", {done_a, len_a}, {1'b1, 16'd1});

        repeat (2) idle_cycle();
        check_eq("q_drained", qa.size() + qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
